datamem_lsu: RTL
================

# datamem_lsu

Parametrised, byte-addressed data memory with RISC-V load/store sizing, replacing the single-word asynchronous data memory in the CPU memory stage. Accepts one load or store per handshake and supports byte, half, word and (64-bit build) double accesses, signed or unsigned. Misaligned accesses that cross a word boundary are split into two sequential RAM accesses. Storage is synchronous-read, byte-enabled RAM, so every access completes through a small state machine with a valid/ready request and a single-cycle response pulse.

## Interface
- DATA_WIDTH, 32: word width; legal values are 32 or 64. BYTES = DATA_WIDTH/8.
- ADDR_WIDTH, 32: byte-address width.
- DEPTH, 1024: number of words; must be a power of 2. The index uses log2(DEPTH) bits above the byte offset.
- clk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous assert, active-low.
- req_valid, in, 1: request present.
- req_ready, out, 1: block can accept a request this cycle.
- req_write, in, 1: 1 = store, 0 = load.
- req_funct3, in, 3: RISC-V funct3. Bits [1:0] give the size: 0 = B, 1 = H, 2 = W, 3 = D. Bit 2 = unsigned (loads only).
- req_addr, in, ADDR_WIDTH: byte address. Address bits above index + offset are ignored.
- req_wdata, in, DATA_WIDTH: store data, taken from the low-order bytes.
- rsp_valid, out, 1: one-cycle pulse; the access is complete.
- rsp_rdata, out, DATA_WIDTH: load result, sign- or zero-extended. Always 0 for stores.
- rsp_err, out, 1: illegal size, qualified by rsp_valid.

## Operation
- Little-endian. Byte offset is req_addr[log2(BYTES)-1:0]. Word index w0 is the next log2(DEPTH) bits.
- Illegal size: size 3 with DATA_WIDTH = 32, or funct3[2] = 1 on a store.
  - No RAM write.
  - Response 1 cycle later with rsp_err = 1 and rsp_rdata = 0.
- Crossing condition: offset + (1 << size) > BYTES.
- States:
  - IDLE: req_ready = 1.
    - On accept, access w0.
    - Store: write the byte-enabled lanes that fit in w0.
    - Load: register w0 into rd_lo.
    - Next state is SPLIT if the access crosses, else RESP.
  - SPLIT: req_ready = 0. Access w1 = (w0 + 1) mod DEPTH, so the last word wraps to word 0.
    - Store: write the remaining bytes to the low lanes of w1.
    - Load: register w1 into rd_hi.
    - Next state is RESP.
  - RESP: rsp_valid = 1 and req_ready = 1.
    - Output rdata is assembled combinationally from {rd_hi, rd_lo} shifted right by offset bytes, then extended.
    - With a new accept, next state follows the IDLE rules; otherwise next state is IDLE.
- Extension: signed loads replicate the top bit of the loaded size; unsigned loads zero-fill.
- Read-after-write: a load accepted the cycle after a store's final write returns the new data.
- RAM contents are not reset or initialised.

## Timing
- Reset values: state = IDLE, req_ready = 1 (after reset), rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, rd_lo = rd_hi = 0.
- Latency is measured from the accept edge (cycle 0):
  - Aligned or non-crossing access: rsp_valid in cycle 1.
  - Crossing access: rsp_valid in cycle 2.
- Throughput:
  - Non-crossing: 1 request per cycle with back-to-back accept in RESP. No IDLE bubble is required.
  - Crossing: 1 request per 2 cycles.
- req_ready is 0 only in SPLIT. Requests presented in SPLIT are held by the requester. The block does not latch them.
- Reset asserted mid-SPLIT store: the word-0 bytes are already written, the word-1 bytes are not, and no response is issued. This partial write is accepted behaviour.
- rsp_rdata and rsp_err hold no meaning when rsp_valid = 0. They are driven to 0.

## Structure
- Shared package datamem_pkg holds:
  - size_e (B, H, W, D);
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW, LD, SD, LWU);
  - state_e (IDLE, SPLIT, RESP);
  - the crossing/legality helper function.
- Sub-module datamem_ram:
  - single port, DEPTH x DATA_WIDTH;
  - per-byte write enable;
  - synchronous registered read;
  - read of a word written in the same edge returns the old data.
- datamem_lsu contains the FSM, the byte-enable and lane-shift generation for stores, and the load assembly and extension.

## Test plan
- Reset, then SW 0xDEADBEEF @0x10, then LW @0x10 → rsp_valid in cycle 1, rsp_rdata = 0xDEADBEEF, rsp_err = 0.
- SB 0x80 @0x11 over word 0xDEADBEEF @0x10 → word becomes 0xDEAD80EF.
  - LB @0x11 → 0xFFFFFF80.
  - LBU @0x11 → 0x00000080.
- SW 0x11223344 @0x0E (crossing):
  - req_ready = 0 in SPLIT; rsp_valid in cycle 2.
  - LW @0x0C → low half 0x3344 at bytes 0x0E–0x0F.
  - LH @0x10 → 0x00001122.
  - LW @0x0E → rsp_valid in cycle 2, rsp_rdata = 0x11223344.
- Wrap-around, DEPTH = 1024: SH 0xA55A @0xFFF → byte 0xFFF = 0x5A, byte 0x000 = 0xA5. LHU @0xFFF → 0x0000A55A.
- DATA_WIDTH = 32 with funct3 = 3 (store and load) → rsp_err = 1 in cycle 1, rsp_rdata = 0, memory unchanged. Store with funct3 = 4 → rsp_err = 1.
- Back-to-back LW @0x0, @0x4, @0x8 with req_valid held → three consecutive rsp_valid cycles. Deassert rst_n during SPLIT → rsp_valid = 0 and state = IDLE immediately.

Source files
------------

// File: rtl/datamem_pkg.sv
// datamem_pkg: shared types, funct3 encodings and access helpers for the
// byte-addressed load/store data memory (datamem_lsu / datamem_ram).
package datamem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        SPLIT,
        RESP
    } state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    // Double size needs a 64-bit word; the unsigned bit has no meaning on stores.
    function automatic logic is_legal(input logic [2:0] f3, input logic wr,
                                      input int unsigned dw);
        if ((f3[1:0] == 2'd3) && (dw == 32)) return 1'b0;
        if (wr && f3[2]) return 1'b0;
        return 1'b1;
    endfunction

    // Access spills into the next word when its last byte lies past the word.
    function automatic logic crosses(input int unsigned off, input logic [1:0] sz,
                                     input int unsigned bytes);
        return (off + (32'd1 << sz)) > bytes;
    endfunction

endpackage

// File: rtl/datamem_ram.sv
// datamem_ram: single-port DEPTH x DATA_WIDTH RAM with per-byte write enable
// and registered read. A read of a word written on the same edge returns the
// old contents. Contents are not reset.
//   clk   : clock
//   addr  : word index
//   be    : byte write enables (bit i writes byte lane i)
//   wdata : write data, lane-aligned
//   rdata : registered read data of addr from the previous edge
module datamem_ram #(
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned DEPTH      = 1024,
    localparam int unsigned BYTES      = DATA_WIDTH / 8,
    localparam int unsigned IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic [IDX_W-1:0]      addr,
    input  logic [BYTES-1:0]      be,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/datamem_lsu.sv
// datamem_lsu: byte-addressed data memory with RISC-V load/store sizing.
// One request per valid/ready handshake; word-crossing accesses take an extra
// SPLIT cycle on the following word (wrapping at DEPTH). Response is a
// single-cycle rsp_valid pulse with extended load data or an error flag.
//   clk, rst_n             : clock, async active-low reset
//   req_valid / req_ready  : request handshake (ready is low only in SPLIT)
//   req_write              : 1 = store, 0 = load
//   req_funct3             : [1:0] size B/H/W/D, [2] unsigned load
//   req_addr, req_wdata    : byte address, store data (low-order bytes)
//   rsp_valid              : access complete
//   rsp_rdata, rsp_err     : load data / illegal-size flag, 0 unless rsp_valid
module datamem_lsu
    import datamem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned BIT_W = $clog2(DATA_WIDTH);

    state_e state, state_nxt;

    logic                  accept;
    logic [OFF_W-1:0]      req_off;
    logic [IDX_W-1:0]      req_idx;
    logic                  req_legal;
    logic                  req_cross;

    logic [2*BYTES-1:0]      st_be;
    logic [2*DATA_WIDTH-1:0] st_data;

    logic [OFF_W-1:0]      off_q;
    size_e                 size_q;
    logic                  uns_q, write_q, err_q, cross_q;
    logic [IDX_W-1:0]      idx_hi_q;
    logic [BYTES-1:0]      be_hi_q;
    logic [DATA_WIDTH-1:0] wd_hi_q;
    logic [DATA_WIDTH-1:0] rd_lo_q;

    logic [IDX_W-1:0]      ram_addr;
    logic [BYTES-1:0]      ram_be;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign req_off   = req_addr[OFF_W-1:0];
    assign req_idx   = req_addr[OFF_W +: IDX_W];
    assign req_legal = is_legal(req_funct3, req_write, DATA_WIDTH);
    assign req_cross = crosses(32'(req_off), req_funct3[1:0], BYTES);
    assign accept    = req_valid && req_ready;

    if (ADDR_WIDTH > OFF_W + IDX_W) begin : g_addr_hi
        // Address bits above index + offset alias onto the same storage.
        logic addr_hi_unused;
        assign addr_hi_unused = ^req_addr[ADDR_WIDTH-1:OFF_W+IDX_W];
    end

    // Store lanes across the two-word window: low half goes to w0, high half to w1.
    always_comb begin
        st_be = '0;
        for (int unsigned i = 0; i < 2*BYTES; i++) begin
            st_be[i] = (i >= 32'(req_off)) &&
                       (i < 32'(req_off) + (32'd1 << req_funct3[1:0]));
        end
        st_data = {{DATA_WIDTH{1'b0}}, req_wdata} << {req_off, 3'b000};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE, RESP: if (accept) state_nxt = (req_legal && req_cross) ? SPLIT : RESP;
            SPLIT:      state_nxt = RESP;
            default:    state_nxt = IDLE;
        endcase
    end

    // Output / RAM control logic
    always_comb begin
        req_ready = (state != SPLIT);
        rsp_valid = (state == RESP);
        ram_addr  = req_idx;
        ram_be    = '0;
        ram_wdata = st_data[DATA_WIDTH-1:0];
        if (state == SPLIT) begin
            ram_addr  = idx_hi_q;
            ram_wdata = wd_hi_q;
            if (write_q) ram_be = be_hi_q;
        end else if (accept && req_write && req_legal) begin
            ram_be = st_be[BYTES-1:0];
        end
    end

    // Request context captured at accept; w0 read data parked during SPLIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_q    <= '0;
            size_q   <= SZ_B;
            uns_q    <= 1'b0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            cross_q  <= 1'b0;
            idx_hi_q <= '0;
            be_hi_q  <= '0;
            wd_hi_q  <= '0;
            rd_lo_q  <= '0;
        end else begin
            if (accept) begin
                off_q    <= req_off;
                size_q   <= size_e'(req_funct3[1:0]);
                uns_q    <= req_funct3[2];
                write_q  <= req_write;
                err_q    <= !req_legal;
                cross_q  <= req_legal && req_cross;
                idx_hi_q <= req_idx + IDX_W'(1);
                be_hi_q  <= st_be[2*BYTES-1:BYTES];
                wd_hi_q  <= st_data[2*DATA_WIDTH-1:DATA_WIDTH];
            end
            if (state == SPLIT) rd_lo_q <= ram_rdata;
        end
    end

    datamem_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .be    (ram_be),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Load assembly: the RAM output register holds w0 (non-crossing) or w1
    // (crossing, with w0 parked in rd_lo_q).
    logic [2*DATA_WIDTH-1:0] ld_pair;
    logic [DATA_WIDTH-1:0]   ld_shift;
    logic [DATA_WIDTH-1:0]   ld_ext;
    logic [BIT_W-1:0]        ld_msb;
    int unsigned             nbits;
    logic                    sign;

    always_comb begin
        ld_pair  = cross_q ? {ram_rdata, rd_lo_q} : {{DATA_WIDTH{1'b0}}, ram_rdata};
        ld_shift = DATA_WIDTH'(ld_pair >> {off_q, 3'b000});
        nbits    = 32'd8 << size_q;
        if (nbits > DATA_WIDTH) nbits = DATA_WIDTH;
        ld_msb   = BIT_W'(nbits - 1);
        sign     = ld_shift[ld_msb] & ~uns_q;
        ld_ext   = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            ld_ext[i] = (i < nbits) ? ld_shift[i] : sign;
        end
    end

    assign rsp_rdata = (rsp_valid && !write_q && !err_q) ? ld_ext : '0;
    assign rsp_err   = rsp_valid && err_q;

endmodule
